joy_socd_ctrl: RTL and testbench

Parametrised multi-player joystick conditioner that replaces the fixed per-player 8-way helper in the arcade top levels. Per player it synchronises and debounces the raw joystick and button bits, then applies a selectable SOCD (opposing-direction) resolution mode and an optional 4-way restriction. It also applies per-button autofire. It sits between the hps_io joystick words and the game core inputs, all on clk_sys.

---
 rtl/joy_socd_ctrl.sv | 168 ++++++++++++++++
 tb/tb_joy_socd_ctrl.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/joy_socd_ctrl.sv
// Multi-player joystick conditioner: 2-flop sync, per-bit debounce, SOCD
// resolution, optional 4-way restriction and per-button autofire.
module joy_socd_ctrl #(
  parameter int PLAYERS   = 2,
  parameter int BUTTONS   = 4,
  parameter int DEB_TICKS = 4,
  parameter int AF_HALF   = 3
) (
  input  logic                              clk_sys,
  input  logic                              I_RESETn,
  input  logic                              ce,
  input  logic [PLAYERS*(4+BUTTONS)-1:0]    joy_in,
  input  logic [1:0]                        socd_mode,
  input  logic                              four_way,
  input  logic [BUTTONS-1:0]                af_en,
  output logic [PLAYERS*(4+BUTTONS)-1:0]    joy_out
);

  localparam int W   = 4 + BUTTONS;
  localparam int N   = PLAYERS * W;
  localparam int DCW = (DEB_TICKS > 0) ? $clog2(DEB_TICKS + 1) : 1;
  localparam int AFW = $clog2(AF_HALF) + 1;

  logic [N-1:0] sync1_q, sync2_q;
  logic [N-1:0] deb, deb_prev_q, press;
  logic [N-1:0] cond_d, joy_out_q;

  always_ff @(posedge clk_sys or negedge I_RESETn) begin
    if (!I_RESETn) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      deb_prev_q <= '0;
      joy_out_q  <= '0;
    end else begin
      sync1_q    <= joy_in;
      sync2_q    <= sync1_q;
      deb_prev_q <= deb;
      joy_out_q  <= cond_d;
    end
  end

  assign press   = deb & ~deb_prev_q;
  assign joy_out = joy_out_q;

  generate
    if (DEB_TICKS == 0) begin : g_nodeb
      assign deb = sync2_q;
    end else begin : g_deb
      for (genvar i = 0; i < N; i++) begin : g_bit
        logic [DCW-1:0] cnt_q;
        logic           d_q;
        always_ff @(posedge clk_sys or negedge I_RESETn) begin
          if (!I_RESETn) begin
            cnt_q <= '0;
            d_q   <= 1'b0;
          end else if (sync2_q[i] == d_q) begin
            cnt_q <= '0;
          end else if (ce) begin
            if (cnt_q == DCW'(DEB_TICKS - 1)) begin
              d_q   <= ~d_q;
              cnt_q <= '0;
            end else begin
              cnt_q <= cnt_q + DCW'(1);
            end
          end
        end
        assign deb[i] = d_q;
      end
    end
  endgenerate

  // Pair bit [1] is the direction that wins simultaneous presses (L on H, U on V).
  // Returns {last_n, first_n, resolved[1:0]}.
  function automatic logic [3:0] resolve_axis(
    input logic [1:0] held,
    input logic [1:0] pr,
    input logic       last_q,
    input logic       first_q,
    input logic [1:0] mode
  );
    logic       last_n;
    logic       first_n;
    logic [1:0] res;
    last_n = pr[1] ? 1'b1 : (pr[0] ? 1'b0 : last_q);
    if (&held)
      first_n = (&pr) ? 1'b1 : (pr[1] ? 1'b0 : (pr[0] ? 1'b1 : first_q));
    else
      first_n = held[1] ? 1'b1 : (held[0] ? 1'b0 : first_q);
    res = held;
    if (&held) begin
      case (mode)
        2'b00:   res = last_n ? 2'b10 : 2'b01;
        2'b01:   res = 2'b00;
        2'b10:   res = first_n ? 2'b10 : 2'b01;
        default: res = 2'b11;
      endcase
    end
    return {last_n, first_n, res};
  endfunction

  generate
    for (genvar p = 0; p < PLAYERS; p++) begin : g_player
      logic [W-1:0] held, pr, cond_p;
      logic last_h_q, last_v_q, first_h_q, first_v_q, last_axis_q;
      logic last_h_d, last_v_d, first_h_d, first_v_d, last_axis_d;
      logic [1:0] h_res, v_res;
      logic [BUTTONS-1:0][AFW-1:0] af_cnt_q, af_cnt_d;
      logic [BUTTONS-1:0] af_phase_q, af_phase_d, btn_out;

      assign held = deb[p*W +: W];
      assign pr   = press[p*W +: W];

      always_comb begin
        {last_h_d, first_h_d, h_res} =
          resolve_axis(held[1:0], pr[1:0], last_h_q, first_h_q, socd_mode);
        {last_v_d, first_v_d, v_res} =
          resolve_axis(held[3:2], pr[3:2], last_v_q, first_v_q, socd_mode);
        last_axis_d = (|pr[3:2]) ? 1'b1 : ((|pr[1:0]) ? 1'b0 : last_axis_q);
        if (four_way && (|h_res) && (|v_res)) begin
          if (last_axis_d) h_res = 2'b00;
          else             v_res = 2'b00;
        end
        af_cnt_d   = af_cnt_q;
        af_phase_d = af_phase_q;
        btn_out    = '0;
        // Output uses the upcoming phase so the press cycle shows high.
        for (int k = 0; k < BUTTONS; k++) begin
          if (pr[4+k]) begin
            af_cnt_d[k]   = '0;
            af_phase_d[k] = 1'b1;
          end else if (held[4+k] && ce) begin
            if (af_cnt_q[k] == AFW'(AF_HALF - 1)) begin
              af_cnt_d[k]   = '0;
              af_phase_d[k] = ~af_phase_q[k];
            end else begin
              af_cnt_d[k] = af_cnt_q[k] + AFW'(1);
            end
          end
          btn_out[k] = af_en[k] ? (held[4+k] & af_phase_d[k]) : held[4+k];
        end
        cond_p = {btn_out, v_res, h_res};
      end

      always_ff @(posedge clk_sys or negedge I_RESETn) begin
        if (!I_RESETn) begin
          last_h_q    <= 1'b0;
          last_v_q    <= 1'b0;
          first_h_q   <= 1'b0;
          first_v_q   <= 1'b0;
          last_axis_q <= 1'b0;
          af_cnt_q    <= '0;
          af_phase_q  <= '0;
        end else begin
          last_h_q    <= last_h_d;
          last_v_q    <= last_v_d;
          first_h_q   <= first_h_d;
          first_v_q   <= first_v_d;
          last_axis_q <= last_axis_d;
          af_cnt_q    <= af_cnt_d;
          af_phase_q  <= af_phase_d;
        end
      end

      assign cond_d[p*W +: W] = cond_p;
    end
  endgenerate

endmodule

// File: tb/tb_joy_socd_ctrl.sv
// Directed bench for joy_socd_ctrl: one instance with debounce bypassed,
// one with DEB_TICKS=4 for the debounce sequence.
module tb_joy_socd_ctrl;

  logic        clk_sys;
  logic        I_RESETn;
  logic        ce0, ce4;
  logic [15:0] joy_in;
  logic [1:0]  socd_mode;
  logic        four_way;
  logic [3:0]  af_en;
  logic [15:0] out0, out4;

  int checks = 0;
  int errors = 0;

  joy_socd_ctrl #(.PLAYERS(2), .BUTTONS(4), .DEB_TICKS(0), .AF_HALF(3)) u_dut0 (
    .clk_sys(clk_sys), .I_RESETn(I_RESETn), .ce(ce0), .joy_in(joy_in),
    .socd_mode(socd_mode), .four_way(four_way), .af_en(af_en), .joy_out(out0)
  );

  joy_socd_ctrl #(.PLAYERS(2), .BUTTONS(4), .DEB_TICKS(4), .AF_HALF(3)) u_dut4 (
    .clk_sys(clk_sys), .I_RESETn(I_RESETn), .ce(ce4), .joy_in(joy_in),
    .socd_mode(socd_mode), .four_way(four_way), .af_en(af_en), .joy_out(out4)
  );

  // clock / reset
  initial clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  task automatic step(input int n);
    repeat (n) @(negedge clk_sys);
  endtask

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // seven idle cycles then one cycle with ce4 high
  task automatic ce_period();
    ce4 = 1'b0;
    step(7);
    ce4 = 1'b1;
    step(1);
    ce4 = 1'b0;
  endtask

  initial begin
    I_RESETn = 1'b0; joy_in = '0; socd_mode = 2'b00; four_way = 1'b0;
    af_en = '0; ce0 = 1'b0; ce4 = 1'b0;
    step(2);
    chk("reset_out0", out0, 16'h0000);
    chk("reset_out4", out4, 16'h0000);
    I_RESETn = 1'b1;
    step(1);

    // all inputs on: L and U win simultaneous presses, buttons pass
    joy_in = 16'hFFFF;
    step(3);
    chk("all_on", out0, 16'hFAFA);

    // asynchronous reset mid-operation
    I_RESETn = 1'b0;
    #1;
    chk("rst_async", out0, 16'h0000);
    @(negedge clk_sys);
    I_RESETn = 1'b1;
    step(1); chk("rel_c1", out0, 16'h0000);
    step(1); chk("rel_c2", out0, 16'h0000);
    step(1); chk("rel_c3", out0, 16'hFAFA);
    joy_in = '0;
    step(3); chk("idle", out0, 16'h0000);

    // last-wins
    joy_in = 16'h0001; step(3);  chk("lw_r", out0, 16'h0001);
    step(7);
    joy_in = 16'h0003; step(2);  chk("lw_latency", out0, 16'h0001);
    step(1);                     chk("lw_l", out0, 16'h0002);
    joy_in = 16'h0001; step(3);  chk("lw_rel_l", out0, 16'h0001);
    joy_in = 16'h0000; step(3);
    joy_in = 16'h0003; step(3);  chk("lw_simul", out0, 16'h0002);
    joy_in = 16'h0000; step(3);
    joy_in = 16'h0008; step(3);
    joy_in = 16'h000C; step(3);  chk("lw_v", out0, 16'h0004);
    joy_in = 16'h0000; step(3);

    // mode sweep with R held then L added
    socd_mode = 2'b10;
    joy_in = 16'h0001; step(3);
    joy_in = 16'h0003; step(3);  chk("fw", out0, 16'h0001);
    socd_mode = 2'b11; step(1);  chk("pass", out0, 16'h0003);
    socd_mode = 2'b01; step(1);  chk("neutral", out0, 16'h0000);
    socd_mode = 2'b00; step(1);  chk("neu_to_lw", out0, 16'h0002);
    joy_in = 16'h0000; step(3);
    socd_mode = 2'b10;
    joy_in = 16'h0003; step(3);  chk("fw_simul", out0, 16'h0002);
    joy_in = 16'h0000; step(3);
    joy_in = 16'h0002; step(3);
    joy_in = 16'h0003; step(3);  chk("fw_l_first", out0, 16'h0002);
    joy_in = 16'h0000; step(3);
    socd_mode = 2'b01;
    joy_in = 16'h0008; step(3);
    joy_in = 16'h000C; step(3);  chk("neutral_v", out0, 16'h0000);
    joy_in = 16'h0000; step(3);
    socd_mode = 2'b00;

    // four-way
    four_way = 1'b1;
    joy_in = 16'h0008; step(3);  chk("4w_u", out0, 16'h0008);
    step(2);
    joy_in = 16'h0009; step(3);  chk("4w_r", out0, 16'h0001);
    joy_in = 16'h0008; step(3);  chk("4w_u_back", out0, 16'h0008);
    joy_in = 16'h0000; step(3);
    joy_in = 16'h0006; step(3);  chk("4w_dl", out0, 16'h0004);
    four_way = 1'b0;   step(1);  chk("4w_off", out0, 16'h0006);
    joy_in = 16'h0000; step(3);

    // player independence and plain buttons
    joy_in = 16'h0301; step(3);  chk("players", out0, 16'h0201);
    joy_in = 16'h0000; step(3);
    joy_in = 16'h8010; step(3);  chk("buttons", out0, 16'h8010);
    joy_in = 16'h0000; step(3);  chk("buttons_rel", out0, 16'h0000);

    // autofire on button 0, button 1 steady
    af_en = 4'b0001; ce0 = 1'b1;
    joy_in = 16'h0030;
    step(2);
    for (int i = 0; i < 20; i++) begin
      step(1);
      chk($sformatf("af_%0d", i), out0,
          16'h0020 | (((i % 6) < 3) ? 16'h0010 : 16'h0000));
    end
    joy_in = 16'h0000; step(3);  chk("af_rel", out0, 16'h0000);
    af_en = 4'b0000; ce0 = 1'b0;

    // debounce: three-tick glitch, then a stable press and release
    step(4);
    joy_in = 16'h0010;
    for (int i = 0; i < 3; i++) begin
      ce_period();
      chk($sformatf("deb_glitch_%0d", i), out4, 16'h0000);
    end
    joy_in = 16'h0000;
    step(4);                     chk("deb_glitch_end", out4, 16'h0000);
    joy_in = 16'h0010;
    for (int i = 0; i < 3; i++) begin
      ce_period();
      chk($sformatf("deb_press_%0d", i), out4, 16'h0000);
    end
    ce_period();                 chk("deb_press_edge", out4, 16'h0000);
    step(1);                     chk("deb_rise", out4, 16'h0010);
    joy_in = 16'h0000;
    for (int i = 0; i < 3; i++) begin
      ce_period();
      chk($sformatf("deb_release_%0d", i), out4, 16'h0010);
    end
    ce_period();
    step(1);                     chk("deb_fall", out4, 16'h0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
